// File: rtl/wb_dpram_port_pkg.sv
// Shared definitions for the Wishbone-to-dual-port-RAM bridge:
// RAM geometry and the bridge FSM state encoding.
package wb_dpram_port_pkg;

  localparam int RAM_AW = 13;
  localparam int RAM_DW = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_WAIT   = 3'd1,
    RD_CAP    = 3'd2,
    RMW_WAIT  = 3'd3,
    RMW_MERGE = 3'd4
  } state_t;

endpackage

// File: rtl/wb_byte_merge.sv
// Byte-lane merge: every lane whose select bit is set comes from new_data,
// all other lanes keep old_data. Purely combinational; shared by the bus bridges.
module wb_byte_merge #(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   old_data,
  input  logic [DW-1:0]   new_data,
  input  logic [DW/8-1:0] sel,
  output logic [DW-1:0]   result
);

  // Lane-by-lane select between stored and incoming bytes
  always_comb begin
    result = old_data;
    for (int i = 0; i < DW/8; i++) begin
      if (sel[i]) result[i*8 +: 8] = new_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/wb_dpram_port.sv
// Wishbone B3 classic slave driving port B of the shared 8Kx16 dual-port RAM.
// The RAM has no byte enables, so partial writes are read-modify-write.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for a request; full/null writes complete from here
//   RD_WAIT   | read address presented, RAM read data arrives next cycle
//   RD_CAP    | capture ram_q into wb_dat_o and ack
//   RMW_WAIT  | partial write: old word being read
//   RMW_MERGE | merge old word with write data, write back and ack
//
// Dropping wb_cyc_i in any wait/capture state abandons the transfer with no
// ack and no RAM write; wb_stb_i is only looked at when a request is accepted.
module wb_dpram_port
  import wb_dpram_port_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic [AW-1:0]   ram_address,
  output logic [DW-1:0]   ram_data,
  output logic            ram_wren,
  input  logic [DW-1:0]   ram_q
);

  state_t          state;
  logic [DW-1:0]   dat_q;
  logic [DW/8-1:0] sel_q;
  logic [DW-1:0]   merged;

  wb_byte_merge #(.DW(DW)) u_merge (
    .old_data (ram_q),
    .new_data (dat_q),
    .sel      (sel_q),
    .result   (merged)
  );

  // Bridge FSM; ack and write enable are single-cycle pulses by default
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wb_ack_o    <= 1'b0;
      ram_wren    <= 1'b0;
      wb_dat_o    <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      ram_wren <= 1'b0;
      case (state)
        IDLE: begin
          // the !wb_ack_o term stops the held request being taken twice
          if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
            dat_q       <= wb_dat_i;
            sel_q       <= wb_sel_i;
            ram_address <= wb_adr_i;
            if (!wb_we_i) begin
              state <= RD_WAIT;
            end else if (wb_sel_i == '1) begin
              ram_data <= wb_dat_i;
              ram_wren <= 1'b1;
              wb_ack_o <= 1'b1;
            end else if (wb_sel_i == '0) begin
              wb_ack_o <= 1'b1;
            end else begin
              state <= RMW_WAIT;
            end
          end
        end
        RD_WAIT:  state <= wb_cyc_i ? RD_CAP : IDLE;
        RD_CAP: begin
          state <= IDLE;
          if (wb_cyc_i) begin
            wb_dat_o <= ram_q;
            wb_ack_o <= 1'b1;
          end
        end
        RMW_WAIT: state <= wb_cyc_i ? RMW_MERGE : IDLE;
        RMW_MERGE: begin
          state <= IDLE;
          if (wb_cyc_i) begin
            ram_data <= merged;
            ram_wren <= 1'b1;
            wb_ack_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
